// File: rtl/gate_exerciser.sv
// gate_exerciser: walks every input vector of a combinational gate in ascending order,
// holds each for DWELL cycles, samples the output and scores it against EXPECT.
module gate_exerciser #(
  parameter int N_IN = 2,
  parameter int DWELL = 10,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] X,
  input  logic            F,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld,
  output logic            cap_vld,
  output logic [N_IN-1:0] cap_idx,
  output logic            cap_f,
  output logic            cap_ok
);

  localparam int NV = 2**N_IN;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            mismatch;

  always_comb begin
    mismatch = (F != EXPECT[idx]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      X              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      cap_vld        <= 1'b0;
      cap_idx        <= '0;
      cap_f          <= 1'b0;
      cap_ok         <= 1'b0;
    end else begin
      cap_vld <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          X <= '0;
          if (start) begin
            err_count      <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          X <= idx;
          if (cnt == CW'(DWELL - 1)) state <= SAMPLE;
          else cnt <= cnt + 1'b1;
        end
        SAMPLE: begin
          cap_f   <= F;
          cap_idx <= idx;
          cap_ok  <= ~mismatch;
          cap_vld <= 1'b1;
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_fail_vld) begin
              first_fail     <= idx;
              first_fail_vld <= 1'b1;
            end
          end
          // pass is decided here so the final vector's mismatch is already counted
          if (idx == N_IN'(NV - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            X     <= '0;
            pass  <= (err_count == '0) && !mismatch;
            state <= FIN;
          end else begin
            idx   <= idx + 1'b1;
            X     <= idx + 1'b1;
            cnt   <= '0;
            state <= DRIVE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized self-checking bench for gate_exerciser: a default AND-scored instance
// and an N_IN=1 inverter-scored instance, both checked against a timeline model.
module tb_gate_exerciser;

  localparam int DW = 10;
  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [1:0] EXP_INV = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [1:0] x;
  logic       f;
  logic       busy, done, pass, first_fail_vld, cap_vld, cap_f, cap_ok;
  logic [2:0] err_count;
  logic [1:0] first_fail, cap_idx;
  logic [3:0] f_tt;

  logic       rst_n_i, start_i;
  logic       x_i, f_i, busy_i, done_i, pass_i, ffv_i, capv_i, capf_i, capok_i;
  logic [1:0] err_i;
  logic       ff_i, capidx_i;
  logic [1:0] inv_tt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign f   = f_tt[x];
  assign f_i = inv_tt[x_i];

  gate_exerciser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(x), .F(f),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld),
    .cap_vld(cap_vld), .cap_idx(cap_idx), .cap_f(cap_f), .cap_ok(cap_ok)
  );

  gate_exerciser #(.N_IN(1), .DWELL(1), .EXPECT(2'b01)) dut_inv (
    .clk(clk), .rst_n(rst_n_i), .start(start_i), .X(x_i), .F(f_i),
    .busy(busy_i), .done(done_i), .pass(pass_i), .err_count(err_i),
    .first_fail(ff_i), .first_fail_vld(ffv_i),
    .cap_vld(capv_i), .cap_idx(capidx_i), .cap_f(capf_i), .cap_ok(capok_i)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // number of wrong answers among the first n vectors of a truth table
  function automatic int misses(input logic [3:0] tt, input logic [3:0] ex, input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (tt[i] != ex[i]) m++;
    return m;
  endfunction

  function automatic int lowest_miss(input logic [3:0] tt, input logic [3:0] ex, input int n);
    for (int i = 0; i < n; i++) if (tt[i] != ex[i]) return i;
    return 0;
  endfunction

  // Called at a negedge with the DUT idle; t counts edges after the accept edge.
  task automatic apply_stimulus(input logic [3:0] tt);
    int p = DW + 1;
    int l = 4 * p;
    int i;
    int nm = misses(tt, EXP_AND, 4);
    f_tt  = tt;
    start = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= l; t++) begin
      if (t < l) begin
        check_output("x", 32'(x), 32'(t / p));
        check_output("busy", 32'(busy), 32'd1);
        check_output("done", 32'(done), 32'd0);
      end else begin
        check_output("x_fin", 32'(x), 32'd0);
        check_output("busy_fin", 32'(busy), 32'd0);
        check_output("done_fin", 32'(done), 32'd1);
        check_output("pass", 32'(pass), 32'(nm == 0));
        check_output("err_count", 32'(err_count), 32'(nm));
        check_output("first_fail_vld", 32'(first_fail_vld), 32'(nm != 0));
        if (nm != 0) check_output("first_fail", 32'(first_fail), 32'(lowest_miss(tt, EXP_AND, 4)));
      end
      if (t > 0 && t % p == 0) begin
        i = t / p - 1;
        check_output("cap_vld", 32'(cap_vld), 32'd1);
        check_output("cap_idx", 32'(cap_idx), 32'(i));
        check_output("cap_f", 32'(cap_f), 32'(tt[i]));
        check_output("cap_ok", 32'(cap_ok), 32'(tt[i] == EXP_AND[i]));
        check_output("err_running", 32'(err_count), 32'(misses(tt, EXP_AND, i + 1)));
      end else begin
        check_output("cap_vld_idle", 32'(cap_vld), 32'd0);
      end
      start = (t < l) && (t == 20 || $urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    check_output("done_after", 32'(done), 32'd0);
    check_output("pass_hold", 32'(pass), 32'(nm == 0));
    check_output("err_hold", 32'(err_count), 32'(nm));
  endtask

  task automatic apply_inverter(input logic [1:0] tt);
    int nm = 0;
    for (int k = 0; k < 2; k++) if (tt[k] != EXP_INV[k]) nm++;
    inv_tt  = tt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      check_output("inv_x", 32'(x_i), (t < 4) ? 32'(t / 2) : 32'd0);
      check_output("inv_busy", 32'(busy_i), 32'(t < 4));
      check_output("inv_done", 32'(done_i), 32'(t == 4));
      check_output("inv_cap_vld", 32'(capv_i), 32'(t == 2 || t == 4));
      if (t == 2 || t == 4) check_output("inv_cap_f", 32'(capf_i), 32'(tt[t / 2 - 1]));
      @(negedge clk);
    end
    check_output("inv_pass", 32'(pass_i), 32'(nm == 0));
    check_output("inv_err", 32'(err_i), 32'(nm));
  endtask

  initial begin
    int k, pulses;
    rst_n = 1'b0; start = 1'b0; f_tt = EXP_AND;
    rst_n_i = 1'b0; start_i = 1'b0; inv_tt = EXP_INV;
    repeat (3) @(negedge clk);
    check_output("rst_x", 32'(x), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_pass", 32'(pass), 32'd0);
    check_output("rst_err", 32'(err_count), 32'd0);
    check_output("rst_ffv", 32'(first_fail_vld), 32'd0);
    check_output("rst_cap_vld", 32'(cap_vld), 32'd0);
    rst_n = 1'b1; rst_n_i = 1'b1;
    @(negedge clk);

    apply_stimulus(EXP_AND);
    apply_stimulus(4'b0000);
    apply_stimulus(4'b1111);
    for (int r = 0; r < 6; r++) apply_stimulus(4'($urandom_range(0, 15)));

    // reset during the drive phase of vector 2 with a stuck-at-1 gate
    f_tt  = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 2 * (DW + 1) + $urandom_range(0, DW - 1);
    repeat (k) @(negedge clk);
    check_output("abort_x_pre", 32'(x), 32'd2);
    check_output("abort_err_pre", 32'(err_count), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort_x", 32'(x), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_err", 32'(err_count), 32'd0);
    check_output("abort_ffv", 32'(first_fail_vld), 32'd0);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_output("abort_no_done", 32'(pulses), 32'd0);
    apply_stimulus(EXP_AND);

    apply_inverter(EXP_INV);
    for (int r = 0; r < 3; r++) apply_inverter(2'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
